mem_ctrl: RTL and testbench

- Single arbiter between the core and the byte-wide unified RAM/IO port.
- Serves 32-bit instruction fetches from the fetcher, and byte/half/word loads and stores from the store-load buffer (SLB).
- Serialises each access into byte beats, reassembles read data little-endian, and returns a one-cycle done pulse to the requester.
- Sits directly upstream of the fetcher's instruction path.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_if.sv | 45 ++++
 rtl/mem_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: FSM encodings,
// load/store size codes, the IO window base and common fill values.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam logic [31:0] IO_ADDR_DEF = 32'h0003_0000;
    localparam logic        TRUE        = 1'b1;
    localparam logic        FALSE       = 1'b0;
    localparam logic [31:0] ZERO_DATA   = '0;

    // Size code low bits select the byte count; the unsigned variants share it.
    function automatic logic [2:0] beat_count(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   beat_count = 3'd1;
            2'b01:   beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response signals and the byte-wide RAM/IO port of the
// memory controller; slave is the controller view, master the environment.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              in_fetcher_ce;
    logic [ADDR_W-1:0] in_fetcher_addr;
    logic              out_fetcher_ce;
    logic [31:0]       out_fetcher_instr;

    logic              in_slb_ce;
    logic              in_slb_wr;
    logic [2:0]        in_slb_funct3;
    logic [ADDR_W-1:0] in_slb_addr;
    logic [31:0]       in_slb_data;
    logic              out_slb_ce;
    logic [31:0]       out_slb_data;

    logic              in_rob_misbranch;
    logic              in_io_buffer_full;

    logic [7:0]        in_ram_data;
    logic [7:0]        out_ram_data;
    logic [ADDR_W-1:0] out_ram_addr;
    logic              out_ram_wr;

    modport slave (
        input  in_fetcher_ce, in_fetcher_addr,
        input  in_slb_ce, in_slb_wr, in_slb_funct3, in_slb_addr, in_slb_data,
        input  in_rob_misbranch, in_io_buffer_full, in_ram_data,
        output out_fetcher_ce, out_fetcher_instr,
        output out_slb_ce, out_slb_data,
        output out_ram_data, out_ram_addr, out_ram_wr
    );

    modport master (
        output in_fetcher_ce, in_fetcher_addr,
        output in_slb_ce, in_slb_wr, in_slb_funct3, in_slb_addr, in_slb_data,
        output in_rob_misbranch, in_io_buffer_full, in_ram_data,
        input  out_fetcher_ce, out_fetcher_instr,
        input  out_slb_ce, out_slb_data,
        input  out_ram_data, out_ram_addr, out_ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetches and SLB loads/stores onto a byte-wide RAM/IO port,
// serialising each access into beats and reassembling read data little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_ADDR = IO_ADDR_DEF,
    parameter int          ADDR_W  = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [23:0]       asm_q, asm_d;

    logic              fetch_pend_q, fetch_pend_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              slb_pend_q, slb_pend_d;
    logic              slb_wr_q, slb_wr_d;
    logic [2:0]        slb_f3_q, slb_f3_d;
    logic [ADDR_W-1:0] slb_addr_q, slb_addr_d;
    logic [31:0]       slb_data_q, slb_data_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_wr_q, ram_wr_d;
    logic              fce_q, fce_d;
    logic [31:0]       instr_q, instr_d;
    logic              sce_q, sce_d;
    logic [31:0]       sdata_q, sdata_d;

    logic              fetch_done, slb_done, io_block;
    logic [2:0]        n_beats;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       rd_word;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        is_io = (a[17:16] == IO_ADDR[17:16]);
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            F3_B:    load_ext = {{24{w[7]}}, w[7:0]};
            F3_H:    load_ext = {{16{w[15]}}, w[15:0]};
            F3_BU:   load_ext = {24'b0, w[7:0]};
            F3_HU:   load_ext = {16'b0, w[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        n_beats   = (state_q == ST_FETCH) ? 3'd4 : beat_count(slb_f3_q);
        base_addr = (state_q == ST_FETCH) ? fetch_addr_q : slb_addr_q;
        io_block  = slb_wr_q && is_io(slb_addr_q) && bus.in_io_buffer_full;
        // The last byte is taken straight from the port on the done edge.
        case (n_beats)
            3'd1:    rd_word = {24'b0, bus.in_ram_data};
            3'd2:    rd_word = {16'b0, bus.in_ram_data, asm_q[7:0]};
            default: rd_word = {bus.in_ram_data, asm_q};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = FALSE;
        fce_d      = FALSE;
        instr_d    = instr_q;
        sce_d      = FALSE;
        sdata_d    = sdata_q;
        fetch_done = FALSE;
        slb_done   = FALSE;

        case (state_q)
            ST_IDLE: begin
                if (slb_pend_q) begin
                    if (!io_block) begin
                        ram_addr_d = slb_addr_q;
                        cnt_d      = 3'd1;
                        if (slb_wr_q) begin
                            state_d    = ST_STORE;
                            ram_wr_d   = TRUE;
                            ram_data_d = slb_data_q[7:0];
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end else if (fetch_pend_q && !bus.in_rob_misbranch) begin
                    state_d    = ST_FETCH;
                    ram_addr_d = fetch_addr_q;
                    cnt_d      = 3'd1;
                end
            end
            ST_FETCH, ST_LOAD: begin
                if (state_q == ST_FETCH && bus.in_rob_misbranch) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q < n_beats) ram_addr_d = base_addr + ADDR_W'(cnt_q);
                    // Byte k arrives two edges after its address was driven.
                    case (cnt_q)
                        3'd2:    asm_d[7:0]   = bus.in_ram_data;
                        3'd3:    asm_d[15:8]  = bus.in_ram_data;
                        3'd4:    asm_d[23:16] = bus.in_ram_data;
                        default: ;
                    endcase
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == n_beats + 3'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (state_q == ST_FETCH) begin
                            fce_d      = TRUE;
                            instr_d    = rd_word;
                            fetch_done = TRUE;
                        end else begin
                            sce_d    = TRUE;
                            sdata_d  = load_ext(slb_f3_q, rd_word);
                            slb_done = TRUE;
                        end
                    end
                end
            end
            ST_STORE: begin
                if (cnt_q == n_beats) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    sce_d    = TRUE;
                    slb_done = TRUE;
                end else if (!io_block) begin
                    ram_addr_d = slb_addr_q + ADDR_W'(cnt_q);
                    ram_data_d = slb_data_q[8*cnt_q[1:0] +: 8];
                    ram_wr_d   = TRUE;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request on the same edge as its port's done wins over the clear.
        fetch_pend_d = fetch_pend_q && !fetch_done;
        fetch_addr_d = fetch_addr_q;
        if (bus.in_rob_misbranch) begin
            fetch_pend_d = FALSE;
        end else if (bus.in_fetcher_ce) begin
            fetch_pend_d = TRUE;
            fetch_addr_d = bus.in_fetcher_addr;
        end

        slb_pend_d = slb_pend_q && !slb_done;
        slb_wr_d   = slb_wr_q;
        slb_f3_d   = slb_f3_q;
        slb_addr_d = slb_addr_q;
        slb_data_d = slb_data_q;
        if (bus.in_slb_ce) begin
            slb_pend_d = TRUE;
            slb_wr_d   = bus.in_slb_wr;
            slb_f3_d   = bus.in_slb_funct3;
            slb_addr_d = bus.in_slb_addr;
            slb_data_d = bus.in_slb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            asm_q        <= '0;
            fetch_pend_q <= FALSE;
            fetch_addr_q <= '0;
            slb_pend_q   <= FALSE;
            slb_wr_q     <= FALSE;
            slb_f3_q     <= '0;
            slb_addr_q   <= '0;
            slb_data_q   <= ZERO_DATA;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_wr_q     <= FALSE;
            fce_q        <= FALSE;
            instr_q      <= ZERO_DATA;
            sce_q        <= FALSE;
            sdata_q      <= ZERO_DATA;
        end else if (rdy) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            fetch_pend_q <= fetch_pend_d;
            fetch_addr_q <= fetch_addr_d;
            slb_pend_q   <= slb_pend_d;
            slb_wr_q     <= slb_wr_d;
            slb_f3_q     <= slb_f3_d;
            slb_addr_q   <= slb_addr_d;
            slb_data_q   <= slb_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_wr_q     <= ram_wr_d;
            fce_q        <= fce_d;
            instr_q      <= instr_d;
            sce_q        <= sce_d;
            sdata_q      <= sdata_d;
        end
    end

    assign bus.out_fetcher_ce    = fce_q;
    assign bus.out_fetcher_instr = instr_q;
    assign bus.out_slb_ce        = sce_q;
    assign bus.out_slb_data      = sdata_q;
    assign bus.out_ram_addr      = ram_addr_q;
    assign bus.out_ram_data      = ram_data_q;
    assign bus.out_ram_wr        = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM model, vector table, corner-case
// sequences and randomized transactions against a byte-array reference model.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic load_img;

    mem_ctrl_if #(.ADDR_W(32)) bus();

    mem_ctrl #(.IO_ADDR(32'h0003_0000), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic [7:0] ram_rd_q;

    // Synchronous RAM: read data for an address appears the cycle after it is driven.
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else if (rdy) begin
            if (bus.out_ram_wr) mem[bus.out_ram_addr[9:0]] <= bus.out_ram_data;
            ram_rd_q <= mem[bus.out_ram_addr[9:0]];
        end
    end
    assign bus.in_ram_data = ram_rd_q;

    typedef struct {
        bit          fetch;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int n_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int n = n_of(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + 32'(i)) & 32'h3FF]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int i = 0; i < n_of(f3); i++) ref_mem[(a + 32'(i)) & 32'h3FF] = 8'(d >> (8 * i));
    endtask

    task automatic drive_req(input bit f, input logic [31:0] fa, input bit s, input bit wr,
                             input logic [2:0] f3, input logic [31:0] sa, input logic [31:0] sd,
                             input bit mb);
        bus.in_fetcher_ce    = f;
        bus.in_fetcher_addr  = fa;
        bus.in_slb_ce        = s;
        bus.in_slb_wr        = wr;
        bus.in_slb_funct3    = f3;
        bus.in_slb_addr      = sa;
        bus.in_slb_data      = sd;
        bus.in_rob_misbranch = mb;
        cycle();
        bus.in_fetcher_ce    = 1'b0;
        bus.in_slb_ce        = 1'b0;
        bus.in_rob_misbranch = 1'b0;
    endtask

    task automatic wait_ce(input bit is_fetch, output int lat, output logic [31:0] data);
        bit got = 0;
        lat  = -1;
        data = '0;
        for (int i = 1; i <= 20 && !got; i++) begin
            cycle();
            if (is_fetch ? bus.out_fetcher_ce : bus.out_slb_ce) begin
                got  = 1;
                lat  = i;
                data = is_fetch ? bus.out_fetcher_instr : bus.out_slb_data;
            end
        end
    endtask

    task automatic run_txn(input string tag, input bit f, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input int exp_lat);
        int lat;
        logic [31:0] got;
        drive_req(f, a, !f, wr, f3, a, d, 1'b0);
        wait_ce(f, lat, got);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (!wr || f) check({tag, " data"}, got, exp);
        cycle();
        check({tag, " pulse"}, {31'b0, f ? bus.out_fetcher_ce : bus.out_slb_ce}, 32'h0);
        if (wr && !f) model_store(a, f3, d);
    endtask

    initial begin : main
        int lat, ls, fs, cnt;
        logic [31:0] got, sd, fd, a, d, exp;
        logic [2:0] f3;
        logic [2:0] ldc [5];
        bit f, wr;

        rst_n = 1'b0;
        rdy   = 1'b1;
        load_img = 1'b0;
        bus.in_io_buffer_full = 1'b0;
        bus.in_fetcher_ce = 1'b0; bus.in_fetcher_addr = '0;
        bus.in_slb_ce = 1'b0; bus.in_slb_wr = 1'b0; bus.in_slb_funct3 = '0;
        bus.in_slb_addr = '0; bus.in_slb_data = '0; bus.in_rob_misbranch = 1'b0;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        ref_mem[32'h20] = 8'h80;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h10; ref_mem[32'h103] = 8'h00;
        ref_mem[32'h200] = 8'h93;
        ref_mem[32'h3FE] = 8'h11; ref_mem[32'h3FF] = 8'h22; ref_mem[32'h000] = 8'h33; ref_mem[32'h001] = 8'h44;
        load_img = 1'b1;
        cycle();
        load_img = 1'b0;
        cycle();

        check("reset ram_addr", bus.out_ram_addr, 32'h0);
        check("reset ram_data", {24'b0, bus.out_ram_data}, 32'h0);
        check("reset ram_wr", {31'b0, bus.out_ram_wr}, 32'h0);
        check("reset ce", {30'b0, bus.out_fetcher_ce, bus.out_slb_ce}, 32'h0);
        check("reset instr", bus.out_fetcher_instr, 32'h0);
        check("reset sdata", bus.out_slb_data, 32'h0);
        rst_n = 1'b1;
        cycle();

        // Latencies count edges from the request edge (grant is one edge later).
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0010_0513, 6};
        vecs[1]  = '{1'b0, 1'b0, 3'b000, 32'h0000_0020, 32'h0, 32'hFFFF_FF80, 3};
        vecs[2]  = '{1'b0, 1'b0, 3'b100, 32'h0000_0020, 32'h0, 32'h0000_0080, 3};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 5};
        vecs[4]  = '{1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 6};
        vecs[5]  = '{1'b0, 1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'hFFFF_DEAD, 4};
        vecs[6]  = '{1'b0, 1'b0, 3'b101, 32'h0000_0040, 32'h0, 32'h0000_BEEF, 4};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0050, 32'h1234_ABCD, 32'h0, 3};
        vecs[8]  = '{1'b0, 1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'h0000_ABCD, 6};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0061, 32'h0000_00FF, 32'h0, 2};
        vecs[10] = '{1'b0, 1'b0, 3'b001, 32'h0000_0060, 32'h0, 32'hFFFF_FF00, 4};
        vecs[11] = '{1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 6};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 32'h0000_0043, 32'h0, 32'hFFFF_FFDE, 3};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 32'h0044_3322, 6};
        for (int i = 0; i < 14; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].fetch, vecs[i].wr, vecs[i].f3,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].lat);

        // Store beats: one byte per cycle, then done with wr low.
        drive_req(1'b0, '0, 1'b1, 1'b1, 3'b010, 32'h70, 32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("sw beat%0d wr", k), {31'b0, bus.out_ram_wr}, 32'h1);
            check($sformatf("sw beat%0d addr", k), bus.out_ram_addr, 32'h70 + 32'(k));
            check($sformatf("sw beat%0d data", k), {24'b0, bus.out_ram_data}, (32'hDEAD_BEEF >> (8 * k)) & 32'hFF);
        end
        cycle();
        check("sw done wr", {31'b0, bus.out_ram_wr}, 32'h0);
        check("sw done ce", {31'b0, bus.out_slb_ce}, 32'h1);
        cycle();
        check("sw after ce", {31'b0, bus.out_slb_ce}, 32'h0);
        model_store(32'h70, 3'b010, 32'hDEAD_BEEF);

        // Simultaneous fetch and load: load first, fetch granted after load done.
        drive_req(1'b1, 32'h100, 1'b1, 1'b0, 3'b000, 32'h20, '0, 1'b0);
        ls = -1; fs = -1; sd = '0; fd = '0;
        for (int i = 1; i <= 14; i++) begin
            cycle();
            if (bus.out_slb_ce) begin ls = i; sd = bus.out_slb_data; end
            if (bus.out_fetcher_ce) begin fs = i; fd = bus.out_fetcher_instr; end
        end
        check("dual load cycle", 32'(ls), 32'd3);
        check("dual load data", sd, 32'hFFFF_FF80);
        check("dual fetch cycle", 32'(fs), 32'd9);
        check("dual fetch data", fd, 32'h0010_0513);

        // Misbranch aborts an in-flight fetch; next fetch completes normally.
        drive_req(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle();
        cycle();
        bus.in_rob_misbranch = 1'b1;
        cycle();
        bus.in_rob_misbranch = 1'b0;
        check("abort no ce 1", {31'b0, bus.out_fetcher_ce}, 32'h0);
        cycle();
        check("abort no ce 2", {31'b0, bus.out_fetcher_ce}, 32'h0);
        drive_req(1'b1, 32'h200, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("abort no ce 3", {31'b0, bus.out_fetcher_ce}, 32'h0);
        wait_ce(1'b1, lat, got);
        check("refetch latency", 32'(lat), 32'd6);
        check("refetch data", got, 32'h0000_0093);
        cycle();

        // Misbranch in the same cycle as a fetch request discards it.
        drive_req(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.out_fetcher_ce) cnt++;
        end
        check("discarded fetch", 32'(cnt), 32'd0);

        // IO store held while the IO buffer is full; a pending fetch waits behind it.
        bus.in_io_buffer_full = 1'b1;
        drive_req(1'b0, '0, 1'b1, 1'b1, 3'b000, 32'h0003_0000, 32'h0000_005A, 1'b0);
        check("io hold 1", {31'b0, bus.out_ram_wr}, 32'h0);
        drive_req(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("io hold 2", {31'b0, bus.out_ram_wr}, 32'h0);
        cycle();
        check("io hold 3", {31'b0, bus.out_ram_wr}, 32'h0);
        bus.in_io_buffer_full = 1'b0;
        cycle();
        check("io beat wr", {31'b0, bus.out_ram_wr}, 32'h1);
        check("io beat addr", bus.out_ram_addr, 32'h0003_0000);
        check("io beat data", {24'b0, bus.out_ram_data}, 32'h5A);
        cycle();
        check("io done wr", {31'b0, bus.out_ram_wr}, 32'h0);
        check("io done ce", {31'b0, bus.out_slb_ce}, 32'h1);
        model_store(32'h0003_0000, 3'b000, 32'h5A);
        wait_ce(1'b1, lat, got);
        check("io fetch latency", 32'(lat), 32'd6);
        check("io fetch data", got, 32'h0010_0513);
        cycle();

        // rdy low mid-load freezes everything; the load resumes and completes.
        drive_req(1'b0, '0, 1'b1, 1'b0, 3'b010, 32'h40, '0, 1'b0);
        cycle();
        cycle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("freeze addr%0d", i), bus.out_ram_addr, 32'h41);
        end
        rdy = 1'b1;
        wait_ce(1'b0, lat, got);
        check("freeze latency", 32'(lat), 32'd4);
        check("freeze data", got, 32'hDEAD_BEEF);
        cycle();

        // Randomized sequential transactions against the byte-array model.
        ldc = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int t = 0; t < 60; t++) begin
            a = 32'h300 + 32'($urandom_range(0, 127));
            d = $urandom;
            case ($urandom_range(0, 2))
                0: begin f = 1'b1; wr = 1'b0; f3 = 3'b010; end
                1: begin f = 1'b0; wr = 1'b0; f3 = ldc[$urandom_range(0, 4)]; end
                default: begin f = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2)); end
            endcase
            exp = model_load(a, f3);
            run_txn($sformatf("rnd%0d", t), f, wr, f3, a, d, exp,
                    wr ? n_of(f3) + 1 : n_of(f3) + 2);
        end

        // Asynchronous reset in the middle of a store clears all outputs at once.
        drive_req(1'b0, '0, 1'b1, 1'b1, 3'b010, 32'h80, 32'h1122_3344, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("mid rst wr", {31'b0, bus.out_ram_wr}, 32'h0);
        check("mid rst addr", bus.out_ram_addr, 32'h0);
        check("mid rst data", {24'b0, bus.out_ram_data}, 32'h0);
        check("mid rst instr", bus.out_fetcher_instr, 32'h0);
        check("mid rst sdata", bus.out_slb_data, 32'h0);
        cycle();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.out_ram_wr || bus.out_slb_ce) cnt++;
        end
        check("post rst idle", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
